wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter sitting between the functional-unit write-back ports and the register-file write ports / ROB completion inputs. Accepts up to NR_WB_PORTS independent result streams (fu_output_t + valid/ready), buffers each in a small per-port FIFO, and drains at most NR_RF_WR results per cycle under round-robin arbitration. Each drained result drives a register-file write and a ROB completion in the same cycle. It lets the core have fewer register-file write ports than FU result ports and gives FUs real back-pressure.

## Interface
- NR_IN, default NR_WB_PORTS (4): number of FU write-back input ports.
- NR_OUT, default NR_RF_WR (2): number of register-file write / completion output ports.
- DEPTH, default 2: entries per input FIFO; power of two, ≥ 1.
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset; one clock domain.
- fuoutput_i[NR_IN]  in  fu_output_t  result from each FU (id, rd, data, we…).
- fuoutput_i_valid  in  NR_IN  per-port result valid.
- fuoutput_i_ready  out  NR_IN  per-port FIFO can accept.
- flush_i  in  1  pipeline flush; discard all buffered results.
- rf_wr_o[NR_OUT]  out  fu_output_t  granted result.
- rf_wr_o_valid  out  NR_OUT  granted result valid.
- completion_o[NR_OUT]  out  completion_port_t  {id, valid} for the ROB.

## Operation
- Per input p: FIFO with read pointer, write pointer and count, each of width $clog2(DEPTH)+1.
- fuoutput_i_ready[p] = (count[p] != DEPTH). Depends only on registered state, never on same-cycle pops or valid.
- Push when valid[p] && ready[p] && !flush_i. A valid while not ready is a protocol violation. The bench asserts it never happens. The issue stage must gate dispatch on ready.
- Arbitration (combinational on FIFO heads):
  - Scan inputs starting at rr_q, wrapping modulo NR_IN.
  - The first non-empty FIFO goes to output 0, the second to output 1, and so on, up to NR_OUT grants.
- Granted heads pop at the clock edge.
- rf_wr_o[k] carries the head of the k-th granted input.
- Ungranted outputs: valid 0, data '0.
- completion_o[k].id = rf_wr_o[k].id. completion_o[k].valid = rf_wr_o_valid[k].
- rr_q update:
  - Any grant this cycle: rr_q ← (index of last granted input + 1) mod NR_IN.
  - No grant: rr_q unchanged.
- flush_i = 1:
  - All rf_wr_o_valid and completion valids are forced 0 that cycle.
  - No pops, no pushes.
  - At the edge, all counts and pointers go to 0. rr_q is kept.
- A full FIFO that pops in a cycle still reports not-ready in that cycle; it becomes ready the next cycle.
- Pointers wrap modulo DEPTH. The count distinguishes full from empty.

## Timing
- Reset (async, rstn=0): counts, pointers and rr_q = 0.
  - All rf_wr_o_valid = 0, completion valids = 0.
  - All fuoutput_i_ready = 1.
- Latency: a result pushed at edge N is visible on rf_wr_o at cycle N+1 at the earliest. There is no same-cycle bypass.
- Throughput: NR_OUT results per cycle sustained. Each input drains at most 1 result per cycle.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, order preserved.
- Per-input ordering is strict FIFO. No ordering is guaranteed across inputs.
- Reset asserted mid-operation discards all buffered results immediately.

## Structure
- fu_output_t, completion_port_t, NR_WB_PORTS and NR_RF_WR come from package C. Add NR_RF_WR = 2 there.
- Sub-module wb_fifo: single-input/single-output FIFO with DEPTH parameter, ports push/pop/flush/head/count. wb_arbiter instantiates NR_IN of them.
- The round-robin multi-grant picker is an always_comb loop in wb_arbiter.

## Test plan
- Reset: hold rstn=0 → all ready=1, all valids 0. Release, idle 5 cycles → outputs stay invalid.
- Single result: port 2 pushes id=7 at edge 0 → cycle 1: rf_wr_o[0].id=7, completion_o[0] = {7, 1}. Cycle 2: nothing valid.
- All four ports push ids 1..4 in the same cycle, rr_q=0:
  - Next cycle: outputs are ids 1 and 2, rr_q becomes 2.
  - Following cycle: ids 3 and 4, rr_q becomes 0.
- Back-pressure: port 0 pushes 3 consecutive cycles while the other ports keep outputs busy.
  - ready[0] drops to 0 when count = 2.
  - No result is lost.
  - Port 0 ids emerge in push order.
- Flush: fill port 1 with 2 entries, assert flush_i one cycle → that cycle all valids 0. Next cycle ready[1]=1, count 0, no stale output.
- Fairness: ports 0 through 3 saturated for 20 cycles → each port gets exactly 10 grants, with no port starved more than 1 cycle.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the write-back arbiter slice.
//   NR_WB_PORTS : FU write-back ports feeding the arbiter
//   NR_RF_WR    : register-file write / ROB completion ports
//   fu_output_t : one FU result (ROB id, destination reg, data, write enable)
//   completion_port_t : ROB completion notification {id, valid}
package wb_arbiter_pkg;

  localparam int NR_WB_PORTS = 4;
  localparam int NR_RF_WR    = 2;
  localparam int ROB_ID_W    = 5;
  localparam int REG_ADDR_W  = 5;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [ROB_ID_W-1:0]   id;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  we;
  } fu_output_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] id;
    logic                valid;
  } completion_port_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the FU write-back side and the arbiter.
//   fuoutput_i / fuoutput_i_valid / fuoutput_i_ready : per-FU result handshake
//   flush_i                                          : discard buffered results
//   rf_wr_o / rf_wr_o_valid / completion_o           : drained results
// master = FU/core side, slave = arbiter.
interface wb_arbiter_if #(
  parameter int NR_IN  = wb_arbiter_pkg::NR_WB_PORTS,
  parameter int NR_OUT = wb_arbiter_pkg::NR_RF_WR
) ();
  import wb_arbiter_pkg::*;

  fu_output_t       fuoutput_i [NR_IN];
  logic [NR_IN-1:0] fuoutput_i_valid;
  logic [NR_IN-1:0] fuoutput_i_ready;
  logic             flush_i;

  fu_output_t        rf_wr_o [NR_OUT];
  logic [NR_OUT-1:0] rf_wr_o_valid;
  completion_port_t  completion_o [NR_OUT];

  modport master (
    output fuoutput_i, fuoutput_i_valid, flush_i,
    input  fuoutput_i_ready, rf_wr_o, rf_wr_o_valid, completion_o
  );

  modport slave (
    input  fuoutput_i, fuoutput_i_valid, flush_i,
    output fuoutput_i_ready, rf_wr_o, rf_wr_o_valid, completion_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Single-in / single-out result FIFO used per FU port.
//   clk, rstn  : clock, async active-low reset
//   push, push_data : write one entry (caller guarantees not full)
//   pop        : drop the head (caller guarantees not empty)
//   flush      : clear all entries at the edge, overrides push/pop
//   head       : current oldest entry (undefined content when empty)
//   count      : number of valid entries, 0..DEPTH
module wb_fifo import wb_arbiter_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  fu_output_t    push_data,
  input  logic          pop,
  input  logic          flush,
  output fu_output_t    head,
  output logic [PW-1:0] count
);

  // Storage index width; pointers carry one spare MSB so the count can
  // share their width, the MSB is never needed for addressing.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fu_output_t    mem [2**AW];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          ptr_msb_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ptr_msb_unused = rd_ptr[PW-1] ^ wr_ptr[PW-1];
  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers NR_IN FU result streams in per-port FIFOs and
// drains up to NR_OUT per cycle to register-file writes / ROB completions
// under round-robin priority.
//   clk, rstn : clock, async active-low reset
//   bus       : wb_arbiter_if slave modport (FU handshakes, flush, outputs)
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int NR_IN  = NR_WB_PORTS,
  parameter int NR_OUT = NR_RF_WR,
  parameter int DEPTH  = 2
) (
  input logic         clk,
  input logic         rstn,
  wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (NR_IN > 1) ? $clog2(NR_IN) : 1;

  fu_output_t    head  [NR_IN];
  logic [PW-1:0] count [NR_IN];
  logic          push  [NR_IN];
  logic          pop   [NR_IN];

  logic          grant_valid [NR_OUT];
  logic [IW-1:0] grant_idx   [NR_OUT];
  logic [IW-1:0] rr_q, rr_d, last_idx;
  logic          any_grant;

  for (genvar p = 0; p < NR_IN; p++) begin : g_port
    // Ready looks only at registered occupancy, so a full FIFO that pops
    // this cycle still refuses until the next one.
    assign bus.fuoutput_i_ready[p] = (count[p] != PW'(DEPTH));
    assign push[p] = bus.fuoutput_i_valid[p] && bus.fuoutput_i_ready[p] && !bus.flush_i;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push[p]),
      .push_data (bus.fuoutput_i[p]),
      .pop       (pop[p]),
      .flush     (bus.flush_i),
      .head      (head[p]),
      .count     (count[p])
    );
  end

  // Multi-grant round-robin: walk from rr_q, hand the k-th non-empty FIFO
  // to output k until the outputs run out.
  always_comb begin
    int idx;
    int n_grant;
    idx       = 0;
    n_grant   = 0;
    any_grant = 1'b0;
    last_idx  = rr_q;
    for (int k = 0; k < NR_OUT; k++) begin
      grant_valid[k] = 1'b0;
      grant_idx[k]   = '0;
    end
    for (int i = 0; i < NR_IN; i++) pop[i] = 1'b0;
    for (int i = 0; i < NR_IN; i++) begin
      idx = (int'(rr_q) + i) % NR_IN;
      if (!bus.flush_i && count[idx] != '0 && n_grant < NR_OUT) begin
        grant_valid[n_grant] = 1'b1;
        grant_idx[n_grant]   = IW'(idx);
        pop[idx]             = 1'b1;
        last_idx             = IW'(idx);
        any_grant            = 1'b1;
        n_grant++;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (any_grant) rr_d = (int'(last_idx) == NR_IN - 1) ? '0 : last_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  for (genvar k = 0; k < NR_OUT; k++) begin : g_out
    assign bus.rf_wr_o[k]       = grant_valid[k] ? head[grant_idx[k]] : '0;
    assign bus.rf_wr_o_valid[k] = grant_valid[k];
    assign bus.completion_o[k]  = completion_port_t'{id: bus.rf_wr_o[k].id, valid: grant_valid[k]};
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NI = 4;
  localparam int NO = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NR_IN(NI), .NR_OUT(NO)) bus ();

  wb_arbiter #(.NR_IN(NI), .NR_OUT(NO), .DEPTH(2)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic fu_output_t mk(input int id);
    fu_output_t r;
    r      = '0;
    r.id   = ROB_ID_W'(id);
    r.rd   = REG_ADDR_W'(id);
    r.data = XLEN'(id) * 32'h0101_0101;
    r.we   = 1'b1;
    return r;
  endfunction

  task automatic idle_inputs();
    for (int p = 0; p < NI; p++) bus.fuoutput_i[p] = '0;
    bus.fuoutput_i_valid = '0;
  endtask

  task automatic drive(input int port, input int id);
    bus.fuoutput_i[port]       = mk(id);
    bus.fuoutput_i_valid[port] = 1'b1;
  endtask

  // Valid on a not-ready port is a protocol violation of the bench itself.
  task automatic step();
    chk("proto", 64'(|(bus.fuoutput_i_valid & ~bus.fuoutput_i_ready)), 64'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] v, input int id0, input int id1);
    fu_output_t e;
    #1;
    chk({tag, "_valid"}, 64'(bus.rf_wr_o_valid), 64'(v));
    chk({tag, "_cvalid"}, 64'({bus.completion_o[1].valid, bus.completion_o[0].valid}), 64'(v));
    for (int k = 0; k < NO; k++) begin
      e = v[k] ? mk((k == 0) ? id0 : id1) : '0;
      chk($sformatf("%s_out%0d", tag, k), 64'(bus.rf_wr_o[k]), 64'(e));
      chk($sformatf("%s_cid%0d", tag, k), 64'(bus.completion_o[k].id), 64'(e.id));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  int grants  [NI];
  int gap     [NI];
  int max_gap [NI];
  int seq_in  [NI];
  int seq_out [NI];
  logic [NI-1:0] hit;
  int prt;

  initial begin
    idle_inputs();
    bus.flush_i = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.fuoutput_i_ready), 64'hF);
    expect_out("rst", 2'b00, 0, 0);
    rstn = 1'b1;
    repeat (5) begin
      step();
      expect_out("idle", 2'b00, 0, 0);
    end

    // single result on port 2
    drive(2, 7);
    step();
    idle_inputs();
    expect_out("single", 2'b01, 7, 0);
    step();
    expect_out("single_after", 2'b00, 0, 0);

    // reset mid-operation discards and restores rr_q = 0
    drive(1, 9);
    drive(3, 11);
    step();
    idle_inputs();
    drive(0, 12);
    drive(1, 13);
    #1;
    rstn = 1'b0;
    expect_out("mid_rst", 2'b00, 0, 0);
    chk("mid_rst_ready", 64'(bus.fuoutput_i_ready), 64'hF);
    idle_inputs();
    step();
    rstn = 1'b1;
    step();
    expect_out("post_rst", 2'b00, 0, 0);

    // all four ports at once, rr_q = 0
    for (int p = 0; p < NI; p++) drive(p, p + 1);
    step();
    idle_inputs();
    expect_out("all4_a", 2'b11, 1, 2);
    step();
    expect_out("all4_b", 2'b11, 3, 4);
    step();
    expect_out("all4_c", 2'b00, 0, 0);
    // rr_q is back at 0: port 0 ranks ahead of port 3
    drive(3, 13);
    drive(0, 10);
    step();
    idle_inputs();
    expect_out("rr_wrap", 2'b11, 10, 13);
    step();
    expect_out("rr_wrap_end", 2'b00, 0, 0);

    // back-pressure on port 0
    drive(0, 10); drive(1, 21); drive(2, 31); drive(3, 41);
    step();
    idle_inputs();
    drive(0, 11); drive(1, 22); drive(2, 32); drive(3, 42);
    expect_out("bp1", 2'b11, 10, 21);
    chk("bp1_ready", 64'(bus.fuoutput_i_ready), 64'hF);
    step();
    idle_inputs();
    drive(0, 12); drive(1, 23);
    expect_out("bp2", 2'b11, 31, 41);
    chk("bp2_ready", 64'(bus.fuoutput_i_ready), 64'h3);
    step();
    idle_inputs();
    expect_out("bp3", 2'b11, 11, 22);
    chk("bp3_ready", 64'(bus.fuoutput_i_ready), 64'hC);
    step();
    expect_out("bp4", 2'b11, 32, 42);
    chk("bp4_ready", 64'(bus.fuoutput_i_ready), 64'hF);
    step();
    expect_out("bp5", 2'b11, 12, 23);
    step();
    expect_out("bp6", 2'b00, 0, 0);

    // flush with port 1 full (rr_q = 2 here)
    drive(1, 51); drive(2, 52); drive(3, 53);
    step();
    idle_inputs();
    drive(1, 54);
    expect_out("fl_fill", 2'b11, 52, 53);
    step();
    idle_inputs();
    bus.flush_i = 1'b1;
    drive(0, 60);
    expect_out("fl_cycle", 2'b00, 0, 0);
    chk("fl_cycle_ready", 64'(bus.fuoutput_i_ready), 64'hD);
    step();
    idle_inputs();
    bus.flush_i = 1'b0;
    expect_out("fl_after", 2'b00, 0, 0);
    chk("fl_after_ready", 64'(bus.fuoutput_i_ready), 64'hF);
    step();
    expect_out("fl_after2", 2'b00, 0, 0);
    // rr_q kept at 0 through the flush: port 1 ahead of port 3
    drive(1, 14); drive(3, 15);
    step();
    idle_inputs();
    expect_out("fl_rr", 2'b11, 14, 15);
    step();
    expect_out("fl_rr_end", 2'b00, 0, 0);

    // fairness: all ports saturated, rr_q = 0
    for (int p = 0; p < NI; p++) begin
      grants[p] = 0; gap[p] = 0; max_gap[p] = 0; seq_in[p] = 0; seq_out[p] = 0;
    end
    for (int cyc = 0; cyc <= 20; cyc++) begin
      #1;
      if (cyc >= 1) begin
        hit = '0;
        for (int k = 0; k < NO; k++) begin
          if (bus.rf_wr_o_valid[k]) begin
            prt = int'(bus.rf_wr_o[k].id[4:3]);
            hit[prt] = 1'b1;
            grants[prt]++;
            chk($sformatf("fair_order_p%0d", prt), 64'(bus.rf_wr_o[k].id[2:0]), 64'(seq_out[prt] % 8));
            seq_out[prt]++;
          end
        end
        for (int p = 0; p < NI; p++) begin
          if (hit[p]) gap[p] = 0;
          else begin
            gap[p]++;
            if (gap[p] > max_gap[p]) max_gap[p] = gap[p];
          end
        end
      end
      idle_inputs();
      if (cyc < 20) begin
        for (int p = 0; p < NI; p++) begin
          if (bus.fuoutput_i_ready[p]) begin
            drive(p, p * 8 + (seq_in[p] % 8));
            seq_in[p]++;
          end
        end
      end
      step();
    end
    for (int p = 0; p < NI; p++) begin
      chk($sformatf("fair_grants_p%0d", p), 64'(grants[p]), 64'd10);
      chk($sformatf("fair_starve_p%0d", p), 64'(max_gap[p] <= 1), 64'd1);
    end
    idle_inputs();
    repeat (6) step();
    expect_out("drain_end", 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
